// File: rtl/mem_arbiter_pkg.sv
// Shared definitions for the fetch/data memory arbiter: state encoding and
// default bus widths.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF = 32;
  localparam int DATA_W_DEF = 32;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_FETCH = 2'd1,
    ST_DATA  = 2'd2,
    ST_DRAIN = 2'd3
  } state_t;

endpackage

// File: rtl/mem_arbiter_watchdog_counter.sv
// Counts unacknowledged memory-request cycles and flags the cycle in which
// the count reaches TIMEOUT_CYCLES; a zero limit disables the watchdog.
module watchdog_counter #(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic inc,
  output logic expired
);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) begin
      r_cnt <= '0;
    end else if (inc) begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  // Fires on the increment that would make the count equal the limit, so the
  // request is dropped after exactly TIMEOUT_CYCLES unacknowledged cycles.
  generate
    if (TIMEOUT_CYCLES == 0) begin : g_off
      assign expired = 1'b0;
    end else begin : g_on
      assign expired = inc && (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1));
    end
  endgenerate

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one single-port memory between instruction fetch and the MEM
// stage; data wins, flushed fetches are drained, stuck requests time out.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W         = ADDR_W_DEF,
  parameter int DATA_W         = DATA_W_DEF,
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  input  logic              if_flush,
  output logic [DATA_W-1:0] if_inst,
  output logic              if_valid,
  output logic              freeze,
  input  logic              dm_rd_en,
  input  logic              dm_wr_en,
  input  logic [ADDR_W-1:0] dm_addr,
  input  logic [DATA_W-1:0] dm_wdata,
  output logic [DATA_W-1:0] dm_rdata,
  output logic              dm_ready,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  input  logic              mem_ack,
  output logic              bus_err
);

  state_t r_state, w_next;
  logic   w_take_data, w_take_fetch, w_fetch_done, w_data_done, w_release;
  logic   w_wd_clr, w_wd_inc, w_expired;

  assign freeze   = if_req & ~if_valid;
  assign w_wd_inc = mem_req & ~mem_ack;
  assign w_wd_clr = (w_next != r_state) && (w_next != ST_IDLE);

  watchdog_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES),
    .CNT_W         (CNT_W)
  ) u_watchdog (
    .clk    (clk),
    .rst    (rst),
    .clr    (w_wd_clr),
    .inc    (w_wd_inc),
    .expired(w_expired)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next       = r_state;
    w_take_data  = 1'b0;
    w_take_fetch = 1'b0;
    w_fetch_done = 1'b0;
    w_data_done  = 1'b0;
    w_release    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (dm_rd_en || dm_wr_en) begin
          w_take_data = 1'b1;
          w_next      = ST_DATA;
        end else if (if_req) begin
          w_take_fetch = 1'b1;
          w_next       = ST_FETCH;
        end
      end
      // An ack always beats the watchdog; a timeout beats a late flush.
      ST_FETCH: begin
        if (mem_ack) begin
          w_release    = 1'b1;
          w_fetch_done = ~if_flush;
          w_next       = ST_IDLE;
        end else if (w_expired) begin
          w_release = 1'b1;
          w_next    = ST_IDLE;
        end else if (if_flush) begin
          w_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        if (mem_ack || w_expired) begin
          w_release = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      ST_DATA: begin
        if (mem_ack) begin
          w_release   = 1'b1;
          w_data_done = 1'b1;
          w_next      = ST_IDLE;
        end else if (w_expired) begin
          w_release = 1'b1;
          w_next    = ST_IDLE;
        end
      end
      default: w_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      if_inst   <= '0;
      if_valid  <= 1'b0;
      dm_rdata  <= '0;
      dm_ready  <= 1'b0;
      bus_err   <= 1'b0;
    end else begin
      if_valid <= w_fetch_done;
      dm_ready <= w_data_done;
      if (w_take_data) begin
        mem_req   <= 1'b1;
        mem_we    <= dm_wr_en;
        mem_addr  <= dm_addr;
        mem_wdata <= dm_wdata;
      end else if (w_take_fetch) begin
        mem_req  <= 1'b1;
        mem_we   <= 1'b0;
        mem_addr <= if_addr;
      end else if (w_release) begin
        mem_req <= 1'b0;
      end
      if (w_fetch_done) begin
        if_inst <= mem_rdata;
      end
      if (w_data_done && !mem_we) begin
        dm_rdata <= mem_rdata;
      end
      if (w_expired) begin
        bus_err <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed scenarios plus a randomized run against a
// transaction-level reference model.
module tb_mem_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int TO = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req, if_flush, if_valid, freeze;
  logic [AW-1:0] if_addr, dm_addr, mem_addr;
  logic [DW-1:0] if_inst, dm_wdata, dm_rdata, mem_wdata, mem_rdata;
  logic          dm_rd_en, dm_wr_en, dm_ready;
  logic          mem_req, mem_we, mem_ack, bus_err;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mem_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .TIMEOUT_CYCLES(TO), .CNT_W(3)
  ) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_flush(if_flush),
    .if_inst(if_inst), .if_valid(if_valid), .freeze(freeze),
    .dm_rd_en(dm_rd_en), .dm_wr_en(dm_wr_en), .dm_addr(dm_addr),
    .dm_wdata(dm_wdata), .dm_rdata(dm_rdata), .dm_ready(dm_ready),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .bus_err(bus_err)
  );

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    if_req = 0; if_addr = '0; if_flush = 0;
    dm_rd_en = 0; dm_wr_en = 0; dm_addr = '0; dm_wdata = '0;
    mem_rdata = '0; mem_ack = 0;
  endtask

  task automatic apply_reset();
    idle_inputs();
    rst = 1;
    next_cyc();
    next_cyc();
    rst = 0;
  endtask

  task automatic test_reset();
    rst = 0;
    idle_inputs();
    if_req = 1; if_addr = 32'h44; mem_ack = 1; mem_rdata = 32'h77;
    next_cyc();
    next_cyc();
    apply_reset();
    @(negedge clk);
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL reset_mem_req: got %b want 0", mem_req); end
    n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL reset_mem_we: got %b want 0", mem_we); end
    n_vec++; if (mem_addr !== '0) begin n_err++; $display("FAIL reset_mem_addr: got %h want 0", mem_addr); end
    n_vec++; if (mem_wdata !== '0) begin n_err++; $display("FAIL reset_mem_wdata: got %h want 0", mem_wdata); end
    n_vec++; if (if_inst !== '0) begin n_err++; $display("FAIL reset_if_inst: got %h want 0", if_inst); end
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL reset_if_valid: got %b want 0", if_valid); end
    n_vec++; if (dm_rdata !== '0) begin n_err++; $display("FAIL reset_dm_rdata: got %h want 0", dm_rdata); end
    n_vec++; if (dm_ready !== 1'b0) begin n_err++; $display("FAIL reset_dm_ready: got %b want 0", dm_ready); end
    n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL reset_bus_err: got %b want 0", bus_err); end
    n_vec++; if (freeze !== 1'b0) begin n_err++; $display("FAIL reset_freeze: got %b want 0", freeze); end
  endtask

  task automatic test_fetch();
    apply_reset();
    if_req = 1; if_addr = 32'h10;
    @(negedge clk);
    n_vec++; if (freeze !== 1'b1) begin n_err++; $display("FAIL fetch_freeze_c0: got %b want 1", freeze); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL fetch_req_c0: got %b want 0", mem_req); end
    next_cyc();
    mem_ack = 1; mem_rdata = 32'hE3A0_1005;
    @(negedge clk);
    n_vec++; if (mem_req !== 1'b1) begin n_err++; $display("FAIL fetch_req_c1: got %b want 1", mem_req); end
    n_vec++; if (mem_addr !== 32'h10) begin n_err++; $display("FAIL fetch_addr_c1: got %h want 10", mem_addr); end
    n_vec++; if (mem_we !== 1'b0) begin n_err++; $display("FAIL fetch_we_c1: got %b want 0", mem_we); end
    n_vec++; if (freeze !== 1'b1) begin n_err++; $display("FAIL fetch_freeze_c1: got %b want 1", freeze); end
    next_cyc();
    mem_ack = 0; mem_rdata = '0;
    @(negedge clk);
    n_vec++; if (if_valid !== 1'b1) begin n_err++; $display("FAIL fetch_valid_c2: got %b want 1", if_valid); end
    n_vec++; if (if_inst !== 32'hE3A0_1005) begin n_err++; $display("FAIL fetch_inst_c2: got %h want e3a01005", if_inst); end
    n_vec++; if (freeze !== 1'b0) begin n_err++; $display("FAIL fetch_freeze_c2: got %b want 0", freeze); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL fetch_req_c2: got %b want 0", mem_req); end
    if_req = 0;
    next_cyc();
    @(negedge clk);
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL fetch_valid_c3: got %b want 0", if_valid); end
  endtask

  task automatic test_priority();
    apply_reset();
    dm_rd_en = 1; dm_addr = 32'h104;
    next_cyc();
    mem_ack = 1; mem_rdata = 32'h0BAD_F00D;
    next_cyc();
    mem_ack = 0;
    @(negedge clk);
    n_vec++; if (dm_ready !== 1'b1) begin n_err++; $display("FAIL rd_ready: got %b want 1", dm_ready); end
    n_vec++; if (dm_rdata !== 32'h0BAD_F00D) begin n_err++; $display("FAIL rd_rdata: got %h want 0badf00d", dm_rdata); end
    dm_rd_en = 0;
    next_cyc();
    if_req = 1; if_addr = 32'h20;
    dm_wr_en = 1; dm_addr = 32'h100; dm_wdata = 32'hDEAD_BEEF;
    next_cyc();
    mem_ack = 1; mem_rdata = 32'h5555_AAAA;
    @(negedge clk);
    n_vec++; if (mem_we !== 1'b1) begin n_err++; $display("FAIL prio_we: got %b want 1", mem_we); end
    n_vec++; if (mem_addr !== 32'h100) begin n_err++; $display("FAIL prio_addr: got %h want 100", mem_addr); end
    n_vec++; if (mem_wdata !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL prio_wdata: got %h want deadbeef", mem_wdata); end
    n_vec++; if (freeze !== 1'b1) begin n_err++; $display("FAIL prio_freeze: got %b want 1", freeze); end
    next_cyc();
    mem_ack = 0;
    @(negedge clk);
    n_vec++; if (dm_ready !== 1'b1) begin n_err++; $display("FAIL prio_ready: got %b want 1", dm_ready); end
    n_vec++; if (dm_rdata !== 32'h0BAD_F00D) begin n_err++; $display("FAIL prio_rdata_kept: got %h want 0badf00d", dm_rdata); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL prio_gap: got %b want 0", mem_req); end
    dm_wr_en = 0;
    next_cyc();
    mem_ack = 1; mem_rdata = 32'h1111_2222;
    @(negedge clk);
    n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h20 || mem_we !== 1'b0) begin
      n_err++; $display("FAIL prio_fetch: got req=%b addr=%h we=%b want 1/20/0", mem_req, mem_addr, mem_we);
    end
    next_cyc();
    mem_ack = 0;
    @(negedge clk);
    n_vec++; if (if_valid !== 1'b1 || if_inst !== 32'h1111_2222) begin
      n_err++; $display("FAIL prio_inst: got v=%b %h want 1 11112222", if_valid, if_inst);
    end
    n_vec++; if (dm_ready !== 1'b0) begin n_err++; $display("FAIL prio_ready_pulse: got %b want 0", dm_ready); end
    if_req = 0;
    next_cyc();
  endtask

  task automatic test_flush_inflight();
    apply_reset();
    if_req = 1; if_addr = 32'h30;
    next_cyc();
    next_cyc();
    if_flush = 1; if_addr = 32'h80;
    next_cyc();
    if_flush = 0;
    @(negedge clk);
    n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h30) begin
      n_err++; $display("FAIL flush_drain_c3: got req=%b addr=%h want 1/30", mem_req, mem_addr);
    end
    next_cyc();
    mem_ack = 1; mem_rdata = 32'h9999_0000;
    next_cyc();
    mem_ack = 0;
    @(negedge clk);
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL flush_novalid_c5: got %b want 0", if_valid); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL flush_req_c5: got %b want 0", mem_req); end
    next_cyc();
    mem_ack = 1; mem_rdata = 32'h0000_0080;
    @(negedge clk);
    n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h80) begin
      n_err++; $display("FAIL flush_refetch_c6: got req=%b addr=%h want 1/80", mem_req, mem_addr);
    end
    next_cyc();
    mem_ack = 0;
    @(negedge clk);
    n_vec++; if (if_valid !== 1'b1 || if_inst !== 32'h80) begin
      n_err++; $display("FAIL flush_refetch_inst: got v=%b %h want 1 80", if_valid, if_inst);
    end
    if_req = 0;
    next_cyc();
  endtask

  task automatic test_flush_ack();
    apply_reset();
    if_req = 1; if_addr = 32'h40;
    next_cyc();
    mem_ack = 1; if_flush = 1; mem_rdata = 32'h4444_4444; if_addr = 32'h44;
    next_cyc();
    mem_ack = 0; if_flush = 0;
    @(negedge clk);
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL flushack_valid: got %b want 0", if_valid); end
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL flushack_idle: got %b want 0", mem_req); end
    n_vec++; if (if_inst !== '0) begin n_err++; $display("FAIL flushack_inst: got %h want 0", if_inst); end
    if_req = 0;
    next_cyc();
  endtask

  task automatic test_timeout();
    apply_reset();
    if_req = 1; if_addr = 32'h50;
    next_cyc();
    for (int c = 1; c <= TO; c++) begin
      @(negedge clk);
      n_vec++; if (mem_req !== 1'b1 || bus_err !== 1'b0) begin
        n_err++; $display("FAIL wd_wait_c%0d: got req=%b err=%b want 1/0", c, mem_req, bus_err);
      end
      next_cyc();
    end
    @(negedge clk);
    n_vec++; if (mem_req !== 1'b0) begin n_err++; $display("FAIL wd_abort_req: got %b want 0", mem_req); end
    n_vec++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL wd_bus_err: got %b want 1", bus_err); end
    n_vec++; if (if_valid !== 1'b0) begin n_err++; $display("FAIL wd_no_valid: got %b want 0", if_valid); end
    if_addr = 32'h54;
    next_cyc();
    mem_ack = 1; mem_rdata = 32'hCAFE_0001;
    @(negedge clk);
    n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h54) begin
      n_err++; $display("FAIL wd_retry: got req=%b addr=%h want 1/54", mem_req, mem_addr);
    end
    next_cyc();
    mem_ack = 0;
    @(negedge clk);
    n_vec++; if (if_valid !== 1'b1 || if_inst !== 32'hCAFE_0001) begin
      n_err++; $display("FAIL wd_retry_inst: got v=%b %h want 1 cafe0001", if_valid, if_inst);
    end
    n_vec++; if (bus_err !== 1'b1) begin n_err++; $display("FAIL wd_sticky: got %b want 1", bus_err); end
    if_req = 0;
    next_cyc();
    rst = 1;
    next_cyc();
    rst = 0;
    @(negedge clk);
    n_vec++; if (bus_err !== 1'b0) begin n_err++; $display("FAIL wd_clear: got %b want 0", bus_err); end
  endtask

  task automatic test_reset_in_data();
    apply_reset();
    dm_rd_en = 1; dm_addr = 32'h200;
    next_cyc();
    @(negedge clk);
    n_vec++; if (mem_req !== 1'b1 || mem_addr !== 32'h200 || mem_we !== 1'b0) begin
      n_err++; $display("FAIL rstd_issue: got req=%b addr=%h we=%b want 1/200/0", mem_req, mem_addr, mem_we);
    end
    next_cyc();
    rst = 1;
    next_cyc();
    rst = 0; dm_rd_en = 0; dm_addr = '0; mem_ack = 1; mem_rdata = 32'h1234_5678;
    @(negedge clk);
    n_vec++; if (mem_req !== 1'b0 || mem_addr !== '0 || dm_ready !== 1'b0 || bus_err !== 1'b0 || if_valid !== 1'b0) begin
      n_err++; $display("FAIL rstd_clear: got req=%b addr=%h rdy=%b err=%b v=%b want all 0",
                        mem_req, mem_addr, dm_ready, bus_err, if_valid);
    end
    next_cyc();
    mem_ack = 0;
    @(negedge clk);
    n_vec++; if (dm_ready !== 1'b0 || mem_req !== 1'b0 || dm_rdata !== '0) begin
      n_err++; $display("FAIL rstd_late_ack: got rdy=%b req=%b rdata=%h want 0/0/0", dm_ready, mem_req, dm_rdata);
    end
  endtask

  task automatic test_random(input int n);
    bit            busy, is_data, flushed, dm_pend, nv, nr;
    int            age;
    logic          m_req, m_we, m_valid, m_ready, m_err;
    logic [AW-1:0] m_addr;
    logic [DW-1:0] m_wdata, m_inst, m_rdata;
    idle_inputs();
    rst = 1;
    next_cyc();
    rst = 0;
    busy = 0; is_data = 0; flushed = 0; dm_pend = 0; age = 0;
    m_req = 0; m_we = 0; m_valid = 0; m_ready = 0; m_err = 0;
    m_addr = '0; m_wdata = '0; m_inst = '0; m_rdata = '0;
    for (int i = 0; i < n; i++) begin
      if (!dm_pend || m_ready) begin
        dm_pend = ($urandom_range(0, 2) == 0);
        if (dm_pend) begin
          dm_rd_en = $urandom_range(0, 1);
          dm_wr_en = ~dm_rd_en;
          dm_addr = $urandom; dm_wdata = $urandom;
        end else begin
          dm_rd_en = 0; dm_wr_en = 0;
        end
      end
      if_req = ($urandom_range(0, 3) != 0);
      if ($urandom_range(0, 3) == 0) if_addr = $urandom;
      if_flush = ($urandom_range(0, 7) == 0);
      mem_ack = ($urandom_range(0, 9) < 4);
      mem_rdata = $urandom;
      rst = ($urandom_range(0, 199) == 0);
      @(negedge clk);
      n_vec++; if (mem_req !== m_req) begin n_err++; $display("FAIL rnd_mem_req @%0d: got %b want %b", i, mem_req, m_req); end
      n_vec++; if (m_req && (mem_we !== m_we || mem_addr !== m_addr)) begin
        n_err++; $display("FAIL rnd_mem_cmd @%0d: got we=%b addr=%h want %b %h", i, mem_we, mem_addr, m_we, m_addr);
      end
      n_vec++; if (m_req && m_we && mem_wdata !== m_wdata) begin
        n_err++; $display("FAIL rnd_mem_wdata @%0d: got %h want %h", i, mem_wdata, m_wdata);
      end
      n_vec++; if (if_valid !== m_valid || if_inst !== m_inst) begin
        n_err++; $display("FAIL rnd_fetch @%0d: got v=%b %h want %b %h", i, if_valid, if_inst, m_valid, m_inst);
      end
      n_vec++; if (dm_ready !== m_ready || dm_rdata !== m_rdata) begin
        n_err++; $display("FAIL rnd_data @%0d: got r=%b %h want %b %h", i, dm_ready, dm_rdata, m_ready, m_rdata);
      end
      n_vec++; if (bus_err !== m_err) begin n_err++; $display("FAIL rnd_bus_err @%0d: got %b want %b", i, bus_err, m_err); end
      n_vec++; if (freeze !== (if_req & ~m_valid)) begin
        n_err++; $display("FAIL rnd_freeze @%0d: got %b want %b", i, freeze, if_req & ~m_valid);
      end
      if (rst) begin
        busy = 0; flushed = 0; age = 0;
        m_req = 0; m_we = 0; m_valid = 0; m_ready = 0; m_err = 0;
        m_addr = '0; m_wdata = '0; m_inst = '0; m_rdata = '0;
      end else begin
        nv = 0; nr = 0;
        if (!busy) begin
          if (dm_rd_en || dm_wr_en) begin
            busy = 1; is_data = 1; flushed = 0; age = 0;
            m_we = dm_wr_en; m_addr = dm_addr; m_wdata = dm_wdata;
          end else if (if_req) begin
            busy = 1; is_data = 0; flushed = 0; age = 0;
            m_we = 0; m_addr = if_addr;
          end
        end else if (mem_ack) begin
          busy = 0;
          if (is_data) begin
            nr = 1;
            if (!m_we) m_rdata = mem_rdata;
          end else if (!flushed && !if_flush) begin
            nv = 1; m_inst = mem_rdata;
          end
        end else if (age + 1 == TO) begin
          busy = 0; m_err = 1;
        end else if (!is_data && !flushed && if_flush) begin
          flushed = 1; age = 0;
        end else begin
          age++;
        end
        m_valid = nv; m_ready = nr; m_req = busy;
      end
      next_cyc();
    end
    rst = 0;
    idle_inputs();
  endtask

  initial begin
    test_reset();
    test_fetch();
    test_priority();
    test_flush_inflight();
    test_flush_ack();
    test_timeout();
    test_reset_in_data();
    test_random(3000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
Shares one single-port instruction/data memory between the fetch stage and the MEM stage of the 5-stage pipeline. Data accesses always win over fetches. A fetch stays pending until its data returns, and the fetch stage freezes its PC register on the `freeze` output. A branch flush discards an in-flight fetch, and a watchdog aborts memory transactions that never complete.

Parameters:
ADDR_W, 32, address width of all address ports
DATA_W, 32, width of the data, instruction and memory data paths
TIMEOUT_CYCLES, 16, cycles a memory request may stay unacknowledged before abort; 0 disables the watchdog
CNT_W, 5, watchdog counter width; must satisfy 2^CNT_W > TIMEOUT_CYCLES

Ports:
clk  in  1  single clock; everything is on the rising edge
rst  in  1  synchronous, active-high reset
if_req  in  1  fetch stage requests the instruction at if_addr
if_addr  in  ADDR_W  fetch address (the PC register output)
if_flush  in  1  branch taken; kills any in-flight fetch
if_inst  out  DATA_W  fetched instruction, valid while if_valid=1
if_valid  out  1  one-cycle pulse: if_inst holds the word for the last accepted fetch
freeze  out  1  stall to the fetch stage; equals if_req & ~if_valid, combinational
dm_rd_en  in  1  MEM stage read request
dm_wr_en  in  1  MEM stage write request; the requester never asserts it together with dm_rd_en
dm_addr  in  ADDR_W  data address; held stable by the requester until dm_ready
dm_wdata  in  DATA_W  write data; held stable until dm_ready
dm_rdata  out  DATA_W  read data, valid while dm_ready=1
dm_ready  out  1  one-cycle pulse: data access complete
mem_req  out  1  request to memory, registered; held until mem_ack
mem_we  out  1  1 = write, registered
mem_addr  out  ADDR_W  registered memory address
mem_wdata  out  DATA_W  registered memory write data
mem_rdata  in  DATA_W  memory read data, sampled in the mem_ack cycle
mem_ack  in  1  memory completes the current request this cycle
bus_err  out  1  sticky flag: a watchdog abort has occurred

Behaviour:
- States are IDLE, FETCH, DATA and DRAIN. On rst the block:
  - enters IDLE;
  - clears mem_req, mem_we, mem_addr, mem_wdata, if_inst, if_valid, dm_rdata, dm_ready, bus_err and the watchdog counter.
- Reset mid-transaction abandons the transaction silently; it produces no pulse.
- IDLE:
  - If dm_rd_en|dm_wr_en: latch dm_addr, dm_wdata and dm_wr_en into mem_addr, mem_wdata and mem_we; set mem_req; go to DATA.
  - Else if if_req: latch if_addr; set mem_we=0 and mem_req=1; go to FETCH.
  - Else: mem_req=0.
  - mem_ack seen in IDLE is ignored.
- FETCH:
  - mem_ack & ~if_flush: if_inst<=mem_rdata, if_valid<=1 for the next cycle only, mem_req<=0, go to IDLE.
  - mem_ack & if_flush: drop the data (no if_valid), mem_req<=0, go to IDLE.
  - ~mem_ack & if_flush: go to DRAIN; mem_req stays 1.
  - Otherwise stay in FETCH.
- DRAIN: wait for mem_ack, then drop the data, set mem_req<=0 and go to IDLE. if_valid is never asserted from DRAIN.
- DATA: on mem_ack, set dm_ready<=1 for the next cycle only. A read also loads dm_rdata<=mem_rdata; a write leaves dm_rdata unchanged. Then set mem_req<=0 and go to IDLE.
- Latency:
  - A request seen in IDLE at cycle N drives mem_req from N+1.
  - With mem_ack at N+1, if_valid or dm_ready is high at N+2.
  - The minimum issue-to-completion time is therefore 2 cycles.
  - Back-to-back accesses are spaced by at least 1 IDLE cycle: mem_req drops for at least 1 cycle between transactions.
- Priority:
  - A data request arriving during FETCH or DRAIN waits, and is granted in the next IDLE cycle ahead of any pending fetch.
  - A simultaneous if_req and data request in IDLE grants data; freeze stays high for the fetch.
- if_flush in IDLE or DATA has no effect. The new PC is requested normally.
- Watchdog:
  - The counter clears on entry to FETCH, DATA or DRAIN and increments each cycle mem_req=1 & ~mem_ack.
  - If it reaches TIMEOUT_CYCLES (with TIMEOUT_CYCLES≠0): mem_req<=0, bus_err<=1, go to IDLE, no completion pulse.
  - bus_err clears only on rst.
  - mem_ack in the same cycle as the limit wins: the access completes normally.
- mem_addr, mem_we and mem_wdata are constant while mem_req=1.

Decomposition:
- Shared pipeline package holds:
  - the state encoding constants ST_IDLE=2'd0, ST_FETCH=2'd1, ST_DATA=2'd2, ST_DRAIN=2'd3;
  - the ADDR_W/DATA_W defaults.
- One sub-module, `watchdog_counter`, with inputs clk, rst, clr, inc and output expired, parameterised by TIMEOUT_CYCLES and CNT_W.
- The FSM and the output registers stay in mem_arbiter.

Test Plan:
- Fetch only: if_req=1, if_addr=0x0000_0010, memory acks 1 cycle after mem_req -> mem_addr=0x10, mem_we=0; if_valid pulses at cycle 2 with if_inst=mem_rdata=0xE3A0_1005; freeze=1 in cycles 0-1 and 0 in cycle 2.
- Priority: in the same cycle, if_req (addr 0x20) and dm_wr_en (addr 0x100, wdata 0xDEAD_BEEF) -> first transaction mem_we=1, mem_addr=0x100; dm_ready pulses; then a fetch to 0x20; dm_rdata unchanged.
- Flush in flight: fetch to 0x30, if_flush at cycle 2, mem_ack at cycle 4 -> no if_valid; mem_req=0 at cycle 5; next fetch to 0x80 issued from IDLE at cycle 5; mem_req=1 at cycle 6.
- Flush coincident with ack -> data dropped, no if_valid, IDLE next cycle.
- Timeout with TIMEOUT_CYCLES=4 and mem_ack never asserted -> mem_req drops after 4 unacked cycles; bus_err=1 and stays 1; next if_req is served normally; bus_err clears only on rst.
- Reset during DATA (rst at cycle 2 of a read) -> all outputs 0 the next cycle, no dm_ready; a late mem_ack in IDLE is ignored.
